// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// muldiv_unit_pkg : op-code encodings, FSM state type and op-class helpers
//                   shared by the RV32IM multiply/divide unit
// Revision 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [4:0] sel);
        return (sel == OP_MUL) || (sel == OP_MULH) || (sel == OP_MULHSU) || (sel == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] sel);
        return (sel == OP_DIV) || (sel == OP_DIVU) || (sel == OP_REM) || (sel == OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_core.sv
// ============================================================================
// muldiv_core : one combinational radix-2 step (shift-add multiply or
//               restoring divide) over a {hi,lo} working register pair
// Revision 1.0
// ============================================================================
`default_nettype none

module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic            div_mode,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_next = hi;
        lo_next = lo;
        if (div_mode) begin
            // hi holds the partial remainder, lo shifts out dividend bits and
            // shifts in quotient bits; a set MSB of diff means a borrow
            shifted = {hi, lo[XLEN-1]};
            diff    = shifted - {1'b0, operand};
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : multi-cycle RV32IM M-extension unit with valid/ready handshake.
//               Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
// Revision 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [4:0]       SELECT,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(XLEN);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  hi, lo, operand;
    logic             div_mode, negate, want_hi, want_rem;

    logic [XLEN-1:0]  hi_next, lo_next, final_res;
    logic             sel_mul, sel_div, sgn1, sgn2, div_by_zero, div_ovf;
    logic [XLEN-1:0]  abs1, abs2, short_res;

    // Negation is applied to the full double-width product so high halves
    // of signed multiplies come out right.
    function automatic logic [XLEN-1:0] fixup(input logic dm, input logic neg,
                                              input logic wh, input logic wr,
                                              input logic [XLEN-1:0] h,
                                              input logic [XLEN-1:0] l);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        p = {h, l};
        if (neg) p = -p;
        v = wr ? h : l;
        if (neg) v = -v;
        return dm ? v : (wh ? p[2*XLEN-1:XLEN] : p[XLEN-1:0]);
    endfunction

    assign BUSY     = (state != S_IDLE);
    assign IN_READY = (state == S_IDLE) & ~FLUSH;

    always_comb begin
        sel_mul     = is_mul_op(SELECT);
        sel_div     = is_div_op(SELECT);
        sgn1        = DATA1[XLEN-1] & ((SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                                       (SELECT == OP_DIV)  || (SELECT == OP_REM));
        sgn2        = DATA2[XLEN-1] & ((SELECT == OP_MULH) || (SELECT == OP_DIV) ||
                                       (SELECT == OP_REM));
        abs1        = sgn1 ? -DATA1 : DATA1;
        abs2        = sgn2 ? -DATA2 : DATA2;
        div_by_zero = sel_div && (DATA2 == '0);
        div_ovf     = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                      (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
        short_res   = '0;
        if (div_by_zero)
            short_res = ((SELECT == OP_DIV) || (SELECT == OP_DIVU)) ? '1 : DATA1;
        else if (div_ovf)
            short_res = (SELECT == OP_DIV) ? DATA1 : '0;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
    assign fast_prod = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
    assign fast_res  = fixup(1'b0, sgn1 ^ sgn2, SELECT != OP_MUL, 1'b0,
                             fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`endif

    muldiv_core #(.XLEN(XLEN)) u_core (
        .div_mode (div_mode),
        .hi       (hi),
        .lo       (lo),
        .operand  (operand),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    assign final_res = fixup(div_mode, negate, want_hi, want_rem, hi_next, lo_next);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            operand   <= '0;
            div_mode  <= 1'b0;
            negate    <= 1'b0;
            want_hi   <= 1'b0;
            want_rem  <= 1'b0;
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            OUT_TAG   <= '0;
        end else if (FLUSH) begin
            state     <= S_IDLE;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        OUT_TAG  <= IN_TAG;
                        div_mode <= sel_div;
                        negate   <= ((SELECT == OP_REM) || (SELECT == OP_REMU)) ? sgn1 : (sgn1 ^ sgn2);
                        want_hi  <= (SELECT == OP_MULH) || (SELECT == OP_MULHSU) || (SELECT == OP_MULHU);
                        want_rem <= (SELECT == OP_REM) || (SELECT == OP_REMU);
                        hi       <= '0;
                        lo       <= sel_div ? abs1 : abs2;
                        operand  <= sel_div ? abs2 : abs1;
                        count    <= CNT_W'(XLEN-1);
                        if (!(sel_mul || sel_div) || div_by_zero || div_ovf) begin
                            state     <= S_DONE;
                            OUT_VALID <= 1'b1;
                            RESULT    <= short_res;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (sel_mul) begin
                            state     <= S_DONE;
                            OUT_VALID <= 1'b1;
                            RESULT    <= fast_res;
                        end
`endif
                        else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi <= hi_next;
                    lo <= lo_next;
                    if (count == '0) begin
                        state     <= S_DONE;
                        OUT_VALID <= 1'b1;
                        RESULT    <= final_res;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        state     <= S_IDLE;
                        OUT_VALID <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed and random self-checking bench for muldiv_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam logic [4:0] MUL    = 5'b01011;
    localparam logic [4:0] MULH   = 5'b01100;
    localparam logic [4:0] MULHSU = 5'b01101;
    localparam logic [4:0] MULHU  = 5'b01110;
    localparam logic [4:0] DIV    = 5'b01111;
    localparam logic [4:0] DIVU   = 5'b10000;
    localparam logic [4:0] REM    = 5'b10001;
    localparam logic [4:0] REMU   = 5'b10010;
    localparam logic [4:0] BADOP  = 5'b11111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [4:0]  SELECT = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [4:0]  IN_TAG = '0;
    logic        IN_READY, OUT_VALID, BUSY;
    logic [31:0] RESULT;
    logic [4:0]  OUT_TAG;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .IN_TAG    (IN_TAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .OUT_TAG   (OUT_TAG),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request, waits for OUT_VALID, then consumes the result.
    // lat counts rising edges from the accepting edge (inclusive); -1 on timeout.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] rtag, output int lat);
        @(negedge CLK);
        SELECT = sel; DATA1 = a; DATA2 = b; IN_TAG = tag; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; DATA1 = ~a; DATA2 = ~b;
        lat = 1;
        @(negedge CLK);
        while (!OUT_VALID && lat < 100) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        if (!OUT_VALID) lat = -1;
        res  = RESULT;
        rtag = OUT_TAG;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (sel)
            MUL:    begin p = {32'b0, a} * {32'b0, b};               return p[31:0];  end
            MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
            MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};         return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
            DIV:    return (b == 0) ? 32'hFFFFFFFF : (ovf ? a : 32'(sa / sb));
            DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            REMU:   return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        tests++; if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests++; if (RESULT !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", RESULT); end
        tests++; if (OUT_TAG !== 5'h0) begin fails++; $display("FAIL reset_out_tag: got %h expected 0", OUT_TAG); end
    endtask

    task automatic test_div_basic();
        logic [31:0] res; logic [4:0] rt; int lat;
        run_op(DIV, 32'h00000100, 32'h00000010, 5'd3, res, rt, lat);
        tests++; if (res !== 32'h00000010) begin fails++; $display("FAIL div_basic: got %h expected 00000010", res); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL div_latency: got %0d expected 33", lat); end
        tests++; if (rt !== 5'd3) begin fails++; $display("FAIL div_tag: got %0d expected 3", rt); end
    endtask

    task automatic test_mul();
        logic [4:0]  sel [5] = '{MULH, MULHSU, MULHU, MUL, MUL};
        logic [31:0] a   [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h12345678};
        logic [31:0] b   [5] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000010};
        logic [31:0] exp [5] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFEB, 32'h23456780};
        logic [31:0] res; logic [4:0] rt; int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(sel[i], a[i], b[i], 5'(i + 1), res, rt, lat);
            tests++; if (res !== exp[i]) begin fails++; $display("FAIL mul_%0d: got %h expected %h", i, res, exp[i]); end
            tests++; if (lat !== MUL_LAT) begin fails++; $display("FAIL mul_lat_%0d: got %0d expected %0d", i, lat, MUL_LAT); end
        end
    endtask

    task automatic test_shortcuts();
        logic [4:0]  sel [7] = '{DIVU, DIV, REM, REMU, DIV, REM, BADOP};
        logic [31:0] a   [7] = '{32'h00001234, 32'h00000005, 32'hFFFFFFF9, 32'h00000007,
                                 32'h80000000, 32'h80000000, 32'h0000ABCD};
        logic [31:0] b   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
        logic [31:0] exp [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007,
                                 32'h80000000, 32'h00000000, 32'h00000000};
        logic [31:0] res; logic [4:0] rt; int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(sel[i], a[i], b[i], 5'(i + 10), res, rt, lat);
            tests++; if (res !== exp[i]) begin fails++; $display("FAIL shortcut_%0d: got %h expected %h", i, res, exp[i]); end
            tests++; if (lat !== 1) begin fails++; $display("FAIL shortcut_lat_%0d: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_signed_div();
        logic [4:0]  sel [6] = '{REM, DIV, DIVU, REMU, DIV, REM};
        logic [31:0] a   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] b   [6] = '{32'd5, 32'd5, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] exp [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        logic [31:0] res; logic [4:0] rt; int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(sel[i], a[i], b[i], 5'(i + 20), res, rt, lat);
            tests++; if (res !== exp[i]) begin fails++; $display("FAIL sdiv_%0d: got %h expected %h", i, res, exp[i]); end
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        @(negedge CLK);
        SELECT = DIV; DATA1 = 32'hFFFFFFF9; DATA2 = 32'd5; IN_TAG = 5'd17; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!OUT_VALID && n < 100) begin @(negedge CLK); n++; end
        tests++; if (!OUT_VALID) begin fails++; $display("FAIL stall_wait: got out_valid %b expected 1", OUT_VALID); end
        bad = 0;
        IN_VALID = 1'b1; SELECT = DIVU;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (RESULT !== 32'hFFFFFFFF || OUT_TAG !== 5'd17 || IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold_%0d: got result %h tag %0d in_ready %b out_valid %b expected FFFFFFFF 17 0 1",
                         i, RESULT, OUT_TAG, IN_READY, OUT_VALID);
            end
        end
        IN_VALID = 1'b0;
        tests++; if (bad !== 0) fails++;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        tests++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            fails++; $display("FAIL stall_release: got out_valid %b in_ready %b expected 0 1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge CLK);
        SELECT = DIV; DATA1 = 32'd1000; DATA2 = 32'd3; IN_TAG = 5'd5; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        @(negedge CLK);
        tests++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL flush_idle: got in_ready %b busy %b expected 1 0", IN_READY, BUSY);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(negedge CLK); if (OUT_VALID) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
        FLUSH = 1'b1; IN_VALID = 1'b1; SELECT = DIV;
        #1;
        tests++; if (IN_READY !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", IN_READY); end
        @(posedge CLK);
        #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        tests++; if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
            fails++; $display("FAIL flush_no_accept: got busy %b out_valid %b expected 0 0", BUSY, OUT_VALID);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        SELECT = DIVU; DATA1 = 32'd999; DATA2 = 32'd7; IN_TAG = 5'd9; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        tests++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b1) begin
            fails++; $display("FAIL rst_mid_ctrl: got out_valid %b busy %b in_ready %b expected 0 0 1", OUT_VALID, BUSY, IN_READY);
        end
        tests++; if (RESULT !== 32'h0 || OUT_TAG !== 5'h0) begin
            fails++; $display("FAIL rst_mid_data: got result %h tag %0d expected 0 0", RESULT, OUT_TAG);
        end
        repeat (40) @(negedge CLK);
        tests++; if (OUT_VALID !== 1'b0) begin fails++; $display("FAIL rst_mid_stale: got %b expected 0", OUT_VALID); end
    endtask

    task automatic test_random();
        logic [4:0]  ops [9] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, BADOP};
        logic [4:0]  sel;
        logic [31:0] a, b, exp, res;
        logic [4:0]  rt;
        int lat, exp_lat;
        for (int i = 0; i < 24; i++) begin
            sel = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = (i % 6 == 0) ? 32'h0 : ((i % 5 == 2) ? 32'($urandom_range(1, 15)) : $urandom);
            exp = ref_result(sel, a, b);
            if (sel == BADOP) exp_lat = 1;
            else if (sel == MUL || sel == MULH || sel == MULHSU || sel == MULHU) exp_lat = MUL_LAT;
            else if (b == 0) exp_lat = 1;
            else if ((sel == DIV || sel == REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) exp_lat = 1;
            else exp_lat = 33;
            run_op(sel, a, b, 5'(i), res, rt, lat);
            tests++; if (res !== exp) begin
                fails++; $display("FAIL rand_%0d op %b a %h b %h: got %h expected %h", i, sel, a, b, res, exp);
            end
            tests++; if (lat !== exp_lat) begin
                fails++; $display("FAIL rand_lat_%0d: got %0d expected %0d", i, lat, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_mul();
        test_shortcuts();
        test_signed_div();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
